data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter base_addr, 32'h0, byte address of word 0 of the array.
REQ-002 Parameter depth_words, 256, number of 32-bit words stored (power of two, 16..4096).
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr_addr  input  32  byte address for instruction fetch (core PC).
REQ-006 instr_out  output  32  registered instruction word for the core's instr_in.
REQ-007 data_addr  input  32  byte address for load/store.
REQ-008 data_rd_wr  input  1  1 = read, 0 = write.
REQ-009 data_in  input  32  store data from the core, right-aligned for byte/half.
REQ-010 access_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
REQ-011 data_out  output  32  registered load data for the core's data_in.
REQ-012 busy  output  1  high while the post-reset clear sweep runs.
REQ-013 data_err  output  1  one-cycle pulse on a rejected data access.
REQ-014 instr_err  output  1  one-cycle pulse on a rejected fetch.

Function
REQ-015 Byte order SHALL be big-endian: byte offset 0 is bits 31:24 of the stored word.
REQ-016 An address is in range iff base_addr <= addr < base_addr + 4*depth_words; word index = (addr - base_addr) >> 2.
REQ-017 Alignment rules: half requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned.
REQ-018 Data read latency SHALL be one cycle: data_out reflects the address presented on the previous edge.
REQ-019 Byte/half reads SHALL return the selected lane zero-extended into data_out[7:0] / data_out[15:0].
REQ-020 A write SHALL commit at the edge where data_rd_wr=0, busy=0, and the access is aligned and in range.
REQ-021 Byte/half writes SHALL modify only the addressed lanes, using data_in[7:0] / data_in[15:0]; other lanes are preserved.
REQ-022 Instruction port: word-only read, one-cycle latency, independent of the data port, active every non-busy cycle.
REQ-023 A rejected data access (misaligned or out of range) SHALL: perform no write, load data_out=0, pulse data_err for one cycle.
REQ-024 A rejected fetch SHALL load instr_out=0 (NOP encoding) and pulse instr_err for one cycle.
REQ-025 Same-cycle data write and fetch of the same word: instr_out returns the pre-write value; a fetch one cycle later returns the new value.
REQ-026 Read of a word written on the previous edge SHALL return the written value (no stale data).
REQ-027 Sweep FSM: states CLEAR and READY; reset enters CLEAR with counter 0.
REQ-028 In CLEAR, one word [counter] is zeroed per cycle and counter increments; after word depth_words-1 is zeroed, the FSM moves to READY and busy falls on that same edge.
REQ-029 While busy: data writes SHALL be ignored, data_out and instr_out are held at 0, and no error pulses are generated.

Reset
REQ-030 On reset, the block SHALL set data_out=0, instr_out=0, data_err=0, instr_err=0, busy=1 and counter=0.
REQ-031 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from word 0; busy SHALL stay high for exactly depth_words cycles after reset deasserts.

Verification
REQ-032 Sweep check: reset 1 cycle, depth_words=16 -> busy high for 16 cycles; then a read of any in-range word returns 0.
REQ-033 Word and byte lanes: write word 0x11223344 to base+8, then read byte at base+9 -> data_out=0x00000022; write byte 0xAA to base+11, then read word at base+8 -> 0x112233AA.
REQ-034 Misaligned access: word write at base+6 -> data_err pulse, memory unchanged; half read at base+5 -> data_out=0, data_err pulse.
REQ-035 Range check: fetch at base+4*depth_words -> instr_out=0 and instr_err pulse; fetch at base-4 -> same response.
REQ-036 Collision: same cycle, write 0xDEADBEEF to base+0 and fetch base+0 (old value 0) -> instr_out=0; the next fetch of base+0 -> 0xDEADBEEF.
REQ-037 Reset during sweep: reset at sweep cycle 5 -> counter restarts at 0, busy remains high for a further depth_words cycles, and no errors are flagged.

Source files
------------

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : Dual-port (fetch + load/store) word memory with big-endian byte
//            lanes, alignment/range checking and a post-reset clear sweep.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   sole clock, all state changes on rising edge
//   reset        in   synchronous active-high reset
//   instr_addr   in   [31:0] fetch byte address (word aligned expected)
//   instr_out    out  [31:0] registered fetched word, 0 on reject/busy
//   data_addr    in   [31:0] load/store byte address
//   data_rd_wr   in   1 = read, 0 = write
//   data_in      in   [31:0] store data, right-aligned for byte/half
//   access_size  in   [1:0]  0 byte, 1 half, 2/3 word
//   data_out     out  [31:0] registered load data, zero-extended lanes
//   busy         out  high while the clear sweep runs
//   data_err     out  one-cycle pulse on a rejected data access
//   instr_err    out  one-cycle pulse on a rejected fetch
// ============================================================================
module data_memory #(
   parameter logic [31:0] base_addr   = 32'h0,
   parameter int          depth_words = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_addr,
   output logic [31:0] instr_out,
   input  logic [31:0] data_addr,
   input  logic        data_rd_wr,
   input  logic [31:0] data_in,
   input  logic [1:0]  access_size,
   output logic [31:0] data_out,
   output logic        busy,
   output logic        data_err,
   output logic        instr_err
);

   localparam int          addr_bits = $clog2(depth_words);
   localparam logic [32:0] span      = 33'(4 * depth_words);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t               state;
   logic [addr_bits-1:0] counter;
   logic [31:0]          mem [depth_words];

   // 33-bit offsets: bit 32 is the borrow, set when the address is below base.
   logic [32:0]          d_off;
   logic [32:0]          i_off;
   logic [addr_bits-1:0] d_idx;
   logic [addr_bits-1:0] i_idx;
   logic                 d_aligned;
   logic                 d_ok;
   logic                 i_ok;

   assign d_off = {1'b0, data_addr}  - {1'b0, base_addr};
   assign i_off = {1'b0, instr_addr} - {1'b0, base_addr};
   assign d_idx = d_off[addr_bits+1:2];
   assign i_idx = i_off[addr_bits+1:2];

   always_comb begin
      d_aligned = 1'b1;
      case (access_size)
         2'd0:    d_aligned = 1'b1;
         2'd1:    d_aligned = ~data_addr[0];
         default: d_aligned = (data_addr[1:0] == 2'b00);
      endcase
   end

   assign d_ok = ~d_off[32] && (d_off < span) && d_aligned;
   assign i_ok = ~i_off[32] && (i_off < span) && (instr_addr[1:0] == 2'b00);

   assign busy = (state == CLEAR);

   // Single write port shared by the clear sweep and data stores.
   // Lane bit 3 is bits 31:24, i.e. byte offset 0 (big-endian).
   logic                 wr_en;
   logic [addr_bits-1:0] wr_idx;
   logic [3:0]           wr_be;
   logic [31:0]          wr_data;

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = d_idx;
      wr_be   = 4'b0000;
      wr_data = 32'h0;
      if (reset) begin
         wr_en = 1'b0;
      end else if (state == CLEAR) begin
         wr_en   = 1'b1;
         wr_idx  = counter;
         wr_be   = 4'b1111;
         wr_data = 32'h0;
      end else if (!data_rd_wr && d_ok) begin
         wr_en = 1'b1;
         case (access_size)
            2'd0: begin
               wr_be   = 4'b1000 >> data_addr[1:0];
               wr_data = {4{data_in[7:0]}};
            end
            2'd1: begin
               wr_be   = data_addr[1] ? 4'b0011 : 4'b1100;
               wr_data = {2{data_in[15:0]}};
            end
            default: begin
               wr_be   = 4'b1111;
               wr_data = data_in;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Load lane selection: shift the addressed lane down to bit 0.
   logic [31:0] rd_word;
   logic [31:0] rd_shift;
   logic [31:0] rd_lane;

   assign rd_word  = mem[d_idx];
   assign rd_shift = rd_word >> {~data_addr[1:0], 3'b000};

   always_comb begin
      rd_lane = rd_word;
      case (access_size)
         2'd0:    rd_lane = {24'h0, rd_shift[7:0]};
         2'd1:    rd_lane = data_addr[1] ? {16'h0, rd_word[15:0]}
                                         : {16'h0, rd_word[31:16]};
         default: rd_lane = rd_word;
      endcase
   end

   // Sweep FSM and registered outputs. Reads sample the array before this
   // edge's write lands, so a same-edge fetch of a stored word sees old data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CLEAR;
         counter   <= '0;
         data_out  <= 32'h0;
         instr_out <= 32'h0;
         data_err  <= 1'b0;
         instr_err <= 1'b0;
      end else if (state == CLEAR) begin
         data_out  <= 32'h0;
         instr_out <= 32'h0;
         data_err  <= 1'b0;
         instr_err <= 1'b0;
         counter   <= counter + 1'b1;
         if (&counter) begin
            state <= READY;
         end
      end else begin
         if (i_ok) begin
            instr_out <= mem[i_idx];
            instr_err <= 1'b0;
         end else begin
            instr_out <= 32'h0;
            instr_err <= 1'b1;
         end
         if (!d_ok) begin
            data_out <= 32'h0;
            data_err <= 1'b1;
         end else begin
            data_err <= 1'b0;
            if (data_rd_wr) begin
               data_out <= rd_lane;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Directed self-checking bench for data_memory (16 words at 0x1000)
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory;

   localparam logic [31:0] base = 32'h0000_1000;
   localparam int          depth = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_addr;
   logic [31:0] instr_out;
   logic [31:0] data_addr;
   logic        data_rd_wr;
   logic [31:0] data_in;
   logic [1:0]  access_size;
   logic [31:0] data_out;
   logic        busy;
   logic        data_err;
   logic        instr_err;

   int checks   = 0;
   int failures = 0;

   data_memory #(
      .base_addr  (base),
      .depth_words(depth)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .instr_addr (instr_addr),
      .instr_out  (instr_out),
      .data_addr  (data_addr),
      .data_rd_wr (data_rd_wr),
      .data_in    (data_in),
      .access_size(access_size),
      .data_out   (data_out),
      .busy       (busy),
      .data_err   (data_err),
      .instr_err  (instr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic dacc(input logic rd, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
      data_rd_wr  = rd;
      access_size = size;
      data_addr   = addr;
      data_in     = wdata;
   endtask

   // Runs the sweep from a deasserted reset; returns busy length and any
   // nonzero output/error seen while busy.
   task automatic sweep(output int len, output int noisy);
      len   = 0;
      noisy = 0;
      while (busy === 1'b1 && len < 40) begin
         tick();
         len++;
         if (data_err !== 1'b0 || instr_err !== 1'b0 ||
             data_out !== 32'h0 || instr_out !== 32'h0) noisy++;
      end
   endtask

   int len;
   int noisy;

   initial begin
      reset      = 1'b1;
      instr_addr = base;
      dacc(1'b1, 2'd2, base, 32'h0);

      // Reset state
      tick();
      check("rst_busy", {31'h0, busy}, 32'h1);
      check("rst_data_out", data_out, 32'h0);
      check("rst_instr_out", instr_out, 32'h0);
      check("rst_errs", {30'h0, data_err, instr_err}, 32'h0);

      // Sweep: a store to word 0 and a bad fetch are both ignored while busy
      reset      = 1'b0;
      instr_addr = base + 32'd64;
      dacc(1'b0, 2'd2, base, 32'hFFFF_FFFF);
      sweep(len, noisy);
      check("sweep_len", 32'(len), 32'd16);
      check("sweep_quiet", 32'(noisy), 32'd0);

      instr_addr = base + 32'd60;
      dacc(1'b1, 2'd2, base + 32'd20, 32'h0);
      tick();
      check("cleared_word5", data_out, 32'h0);
      check("cleared_fetch15", instr_out, 32'h0);
      check("cleared_no_ierr", {31'h0, instr_err}, 32'h0);
      dacc(1'b1, 2'd2, base, 32'h0);
      tick();
      check("busy_write_ignored", data_out, 32'h0);

      // Word and byte lanes
      dacc(1'b0, 2'd2, base + 32'd8, 32'h1122_3344);
      tick();
      dacc(1'b1, 2'd0, base + 32'd9, 32'h0);
      tick();
      check("byte_rd_9", data_out, 32'h0000_0022);
      check("byte_rd_no_err", {31'h0, data_err}, 32'h0);
      dacc(1'b0, 2'd0, base + 32'd11, 32'hFFFF_FFAA);
      tick();
      dacc(1'b1, 2'd2, base + 32'd8, 32'h0);
      tick();
      check("word_after_byte_wr", data_out, 32'h1122_33AA);
      dacc(1'b1, 2'd1, base + 32'd10, 32'h0);
      tick();
      check("half_rd_10", data_out, 32'h0000_33AA);
      dacc(1'b0, 2'd1, base + 32'd8, 32'h1234_BEEF);
      tick();
      dacc(1'b1, 2'd3, base + 32'd8, 32'h0);
      tick();
      check("word_after_half_wr", data_out, 32'hBEEF_33AA);
      dacc(1'b1, 2'd0, base + 32'd8, 32'h0);
      tick();
      check("byte_rd_8", data_out, 32'h0000_00BE);

      // Misaligned accesses
      dacc(1'b0, 2'd2, base + 32'd6, 32'hFFFF_FFFF);
      tick();
      check("misal_wr_err", {31'h0, data_err}, 32'h1);
      check("misal_wr_out", data_out, 32'h0);
      dacc(1'b1, 2'd2, base + 32'd4, 32'h0);
      tick();
      check("misal_wr_pulse_end", {31'h0, data_err}, 32'h0);
      check("misal_wr_unchanged", data_out, 32'h0);
      dacc(1'b1, 2'd2, base + 32'd8, 32'h0);
      tick();
      check("word8_intact", data_out, 32'hBEEF_33AA);
      dacc(1'b1, 2'd1, base + 32'd5, 32'h0);
      tick();
      check("misal_half_out", data_out, 32'h0);
      check("misal_half_err", {31'h0, data_err}, 32'h1);
      dacc(1'b1, 2'd2, base + 32'd64, 32'h0);
      tick();
      check("oor_data_err", {31'h0, data_err}, 32'h1);
      dacc(1'b1, 2'd2, base + 32'd8, 32'h0);

      // Fetch port range checks
      instr_addr = base + 32'd8;
      tick();
      check("fetch8", instr_out, 32'hBEEF_33AA);
      check("fetch8_no_err", {31'h0, instr_err}, 32'h0);
      instr_addr = base + 32'd64;
      tick();
      check("fetch_top_out", instr_out, 32'h0);
      check("fetch_top_err", {31'h0, instr_err}, 32'h1);
      instr_addr = base - 32'd4;
      tick();
      check("fetch_below_out", instr_out, 32'h0);
      check("fetch_below_err", {31'h0, instr_err}, 32'h1);
      instr_addr = base + 32'd8;
      tick();
      check("fetch_recover", instr_out, 32'hBEEF_33AA);
      check("fetch_err_cleared", {31'h0, instr_err}, 32'h0);

      // Store/fetch collision on word 0
      instr_addr = base;
      dacc(1'b0, 2'd2, base, 32'hDEAD_BEEF);
      tick();
      check("collide_old", instr_out, 32'h0);
      dacc(1'b1, 2'd2, base, 32'h0);
      tick();
      check("collide_new", instr_out, 32'hDEAD_BEEF);
      check("rd_after_wr", data_out, 32'hDEAD_BEEF);

      // Reset at sweep cycle 5 restarts the full sweep
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      check("rst2_busy", {31'h0, busy}, 32'h1);
      reset      = 1'b0;
      instr_addr = base - 32'd4;
      dacc(1'b1, 2'd2, base + 32'd1, 32'h0);
      sweep(len, noisy);
      check("sweep2_len", 32'(len), 32'd16);
      check("sweep2_quiet", 32'(noisy), 32'd0);
      instr_addr = base + 32'd8;
      dacc(1'b1, 2'd2, base, 32'h0);
      tick();
      check("sweep2_word0", data_out, 32'h0);
      check("sweep2_word2", instr_out, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
